memory_stage_ext: RTL



---
 rtl/memory_stage_ext.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage_ext.sv
`default_nettype none
// ============================================================================
// memory_stage_ext : MIPS MEM stage with data memory, sized/extended loads,
//                    wait-latency stall handshake and misalignment detection.
//                    Optional MEMORY_IO_PORT_EN exposes the array on ioMemory.
// Revision: 1.0
// ============================================================================
module memory_stage_ext #(
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 0,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validInput,
  input  logic                      memToRegInput,
  input  logic                      regWriteInput,
  input  logic                      memWriteInput,
  input  logic                      memReadInput,
  input  logic [1:0]                memSizeInput,
  input  logic                      memUnsignedInput,
  input  logic [31:0]               aluResultInput,
  input  logic [31:0]               memWriteDataInput,
  input  logic [REG_ADDR_WIDTH-1:0] regWriteAddressInput,
  output logic                      stallOutput,
  output logic                      validOutput,
  output logic                      memToRegOutput,
  output logic                      regWriteOutput,
  output logic                      misalignOutput,
  output logic [31:0]               dataMemoryOutput,
  output logic [31:0]               aluResultOutput,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddressOutput
`ifdef MEMORY_IO_PORT_EN
  ,
  output logic [32*DEPTH-1:0]       ioMemory
`endif
);

  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT  = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [31:0]               mem_q [DEPTH];
  logic                      valid_q, memToReg_q, regWrite_q, misalign_q;
  logic [31:0]               data_q, alu_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;

  logic              w_access, w_misaligned, w_complete, w_store;
  logic [ADDR_W-1:0] w_index;
  logic [1:0]        w_lane;
  logic [31:0]       w_word, w_load, w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;

  assign w_access = validInput & (memReadInput | memWriteInput);
  assign w_lane   = aluResultInput[1:0];
  assign w_index  = aluResultInput[ADDR_W+1:2];
  // Size 11 is handled as a word, so bit 1 alone selects the word alignment rule.
  assign w_misaligned = w_access &
                        (((memSizeInput == SIZE_HALF) & w_lane[0]) |
                         (memSizeInput[1] & (w_lane != 2'b00)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access && !w_misaligned && (LATENCY > 0)) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          w_complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          w_complete = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stallOutput = reset & ~w_complete;
  assign w_store     = w_complete & w_access & memWriteInput & ~w_misaligned;

  assign w_word = mem_q[w_index];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load  = w_word;
    w_be    = 4'b1111;
    w_wdata = memWriteDataInput;
    case (memSizeInput)
      SIZE_BYTE: begin
        w_load  = memUnsignedInput ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{memWriteDataInput[7:0]}};
      end
      SIZE_HALF: begin
        w_load  = memUnsignedInput ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{memWriteDataInput[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      valid_q    <= 1'b0;
      memToReg_q <= 1'b0;
      regWrite_q <= 1'b0;
      misalign_q <= 1'b0;
      data_q     <= 32'd0;
      alu_q      <= 32'd0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_store) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) mem_q[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
      end
      // Edges that do not complete an instruction hand a bubble to WB.
      if (w_complete && validInput) begin
        valid_q    <= 1'b1;
        memToReg_q <= memToRegInput;
        regWrite_q <= regWriteInput & ~w_misaligned;
        misalign_q <= w_misaligned;
        data_q     <= (memReadInput && !w_misaligned) ? w_load : 32'd0;
        alu_q      <= aluResultInput;
        rd_q       <= regWriteAddressInput;
      end else begin
        valid_q    <= 1'b0;
        memToReg_q <= 1'b0;
        regWrite_q <= 1'b0;
        misalign_q <= 1'b0;
        data_q     <= 32'd0;
        alu_q      <= 32'd0;
        rd_q       <= '0;
      end
    end
  end

  assign validOutput           = valid_q;
  assign memToRegOutput        = memToReg_q;
  assign regWriteOutput        = regWrite_q;
  assign misalignOutput        = misalign_q;
  assign dataMemoryOutput      = data_q;
  assign aluResultOutput       = alu_q;
  assign regWriteAddressOutput = rd_q;

`ifdef MEMORY_IO_PORT_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_io_mirror
    assign ioMemory[32*g +: 32] = mem_q[g];
  end
`endif

endmodule
`default_nettype wire
